// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM encoding, frame geometry
// and small helpers that classify a fully assembled 11-bit frame.
package ps2_pkg;

    // Receiver FSM encoding
    typedef enum logic [1:0] {
        idle = 2'b00,
        dps  = 2'b01,
        load = 2'b10
    } ps2_state_t;

    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = 8;

    // Prefix byte a keyboard sends ahead of a key-release code
    localparam logic [DATA_BITS-1:0] BREAK_CODE = 8'hF0;

    // Frame layout after assembly: {stop, parity, d[7:0], start}
    typedef logic [FRAME_BITS-1:0] ps2_frame_t;

    // Start bit must be low and stop bit high for the frame to be well formed
    function automatic logic frame_framing_ok(input ps2_frame_t f);
        return (f[0] == 1'b0) && (f[FRAME_BITS-1] == 1'b1);
    endfunction

    // Odd parity over data plus parity bit
    function automatic logic frame_parity_ok(input ps2_frame_t f);
        return ^f[FRAME_BITS-2:1];
    endfunction

    // Data byte carried by the frame
    function automatic logic [DATA_BITS-1:0] frame_data(input ps2_frame_t f);
        return f[DATA_BITS:1];
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the raw PS/2 pins and debounces the clock line. Produces the
// synchronised data bit and a one-cycle strobe on each filtered falling edge
// of the PS/2 clock.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic ps2d_s,
    output logic fall_edge
);

    logic [1:0]            c_sync;
    logic [1:0]            d_sync;
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  filt_reg;
    logic                  filt_next;

    // Two-flop synchronisers, debounce history and filtered clock level.
    // Idle PS/2 lines are high, so everything resets to ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_sync   <= 2'b11;
            d_sync   <= 2'b11;
            filt_sr  <= '1;
            filt_reg <= 1'b1;
        end else begin
            c_sync   <= {c_sync[0], ps2c};
            d_sync   <= {d_sync[0], ps2d};
            filt_sr  <= {filt_sr[FILTER_LEN-2:0], c_sync[1]};
            filt_reg <= filt_next;
        end
    end

    // Level changes only once the whole history agrees; mixed history holds
    always_comb begin
        filt_next = filt_reg;
        if (&filt_sr)
            filt_next = 1'b1;
        else if (~|filt_sr)
            filt_next = 1'b0;
    end

    // Edge strobe is high in the single cycle before filt_reg drops
    always_comb begin
        fall_edge = filt_reg & ~filt_next;
        ps2d_s    = d_sync[1];
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver. Deserialises 11-bit frames sampled on the
// filtered falling edge of ps2c, checks start/stop/parity and reports the
// result with single-cycle ticks. A stalled frame is abandoned after
// TIMEOUT_CYCLES without a clock edge.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ps2c,
    input  logic                 ps2d,
    input  logic                 rx_en,
    output logic [DATA_BITS-1:0] scan_code,
    output logic                 scan_done_tick,
    output logic                 parity_err_tick,
    output logic                 frame_err_tick,
    output logic                 busy
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t  state, state_next;
    ps2_frame_t  sr;
    ps2_frame_t  sr_shift;
    logic [3:0]  bit_cnt;
    logic [TO_W-1:0] to_cnt;
    logic        ps2d_s;
    logic        fall_edge;
    logic        timeout;
    logic        last_bit;

    ps2_clk_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c      (ps2c),
        .ps2d      (ps2d),
        .ps2d_s    (ps2d_s),
        .fall_edge (fall_edge)
    );

    // Shared decode: next shift value, stop-bit edge and timeout expiry
    always_comb begin
        sr_shift = {ps2d_s, sr[FRAME_BITS-1:1]};
        last_bit = fall_edge && (bit_cnt == 4'd0);
        timeout  = !fall_edge && (to_cnt == TO_MAX);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= idle;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            idle: if (fall_edge && rx_en) state_next = dps;
            dps: begin
                if (last_bit)
                    state_next = load;
                else if (timeout)
                    state_next = idle;
            end
            load:    state_next = idle;
            default: state_next = idle;
        endcase
    end

    // Outputs: frame verdict is decoded from the assembled frame in load;
    // a timeout reports as a frame error straight out of dps
    always_comb begin
        scan_done_tick  = 1'b0;
        parity_err_tick = 1'b0;
        frame_err_tick  = 1'b0;
        busy            = (state != idle);
        case (state)
            dps: frame_err_tick = timeout;
            load: begin
                if (!frame_framing_ok(sr))
                    frame_err_tick = 1'b1;
                else if (!frame_parity_ok(sr))
                    parity_err_tick = 1'b1;
                else
                    scan_done_tick = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: shift register, bit and timeout counters, scan code.
    // scan_code is loaded on the same edge that enters load so the new
    // byte and scan_done_tick become visible together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr        <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            scan_code <= '0;
        end else begin
            case (state)
                idle: begin
                    if (fall_edge && rx_en) begin
                        sr      <= sr_shift;
                        bit_cnt <= 4'd9;
                        to_cnt  <= '0;
                    end
                end
                dps: begin
                    if (fall_edge) begin
                        sr     <= sr_shift;
                        to_cnt <= '0;
                        if (bit_cnt != 4'd0)
                            bit_cnt <= bit_cnt - 4'd1;
                        else if (frame_framing_ok(sr_shift) && frame_parity_ok(sr_shift))
                            scan_code <= frame_data(sr_shift);
                    end else if (timeout) begin
                        sr      <= '0;
                        to_cnt  <= '0;
                        bit_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: drives PS/2 frames bit by bit and checks ticks,
// scan_code, busy and exact tick timing against hand-derived values.
module tb_ps2_rx;

    localparam int FL   = 8;
    localparam int TO   = 400;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2c;
    logic       ps2d;
    logic       rx_en;
    logic [7:0] scan_code;
    logic       scan_done_tick;
    logic       parity_err_tick;
    logic       frame_err_tick;
    logic       busy;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;
    int n_perr = 0;
    int n_ferr = 0;
    int n_multi = 0;
    int n_busy = 0;
    int last_done_cyc = 0;
    int last_ferr_cyc = 0;
    int fall_cyc = 0;
    int b_done, b_perr, b_ferr, b_busy;

    ps2_rx #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .ps2c            (ps2c),
        .ps2d            (ps2d),
        .rx_en           (rx_en),
        .scan_code       (scan_code),
        .scan_done_tick  (scan_done_tick),
        .parity_err_tick (parity_err_tick),
        .frame_err_tick  (frame_err_tick),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Tick monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            if (scan_done_tick) begin n_done++; last_done_cyc = cyc; end
            if (parity_err_tick) n_perr++;
            if (frame_err_tick) begin n_ferr++; last_ferr_cyc = cyc; end
            if (32'(scan_done_tick) + 32'(parity_err_tick) + 32'(frame_err_tick) > 1) n_multi++;
            if (busy) n_busy++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_done = n_done;
        b_perr = n_perr;
        b_ferr = n_ferr;
        b_busy = n_busy;
    endtask

    // Drive nbits of a frame; optional 3-cycle low glitch in the high phase of bit 4
    task automatic send(input logic [7:0] d, input logic par_flip, input logic stop_v,
                        input int nbits, input logic glitch);
        logic [10:0] f;
        f = {stop_v, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2d = f[i];
            repeat (HALF) @(negedge clk);
            ps2c = 1'b0;
            fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2c = 1'b1;
            if (glitch && i == 4) begin
                repeat (10) @(negedge clk);
                ps2c = 1'b0;
                repeat (3) @(negedge clk);
                ps2c = 1'b1;
            end
        end
        repeat (HALF) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        rx_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_scan_code", 32'(scan_code), 32'h00);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ticks", 32'({scan_done_tick, parity_err_tick, frame_err_tick}), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // Valid 0x1C with exact latency
        snap();
        send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        chk("v1c_done", 32'(n_done - b_done), 32'd1);
        chk("v1c_errs", 32'(n_perr - b_perr + n_ferr - b_ferr), 32'd0);
        chk("v1c_code", 32'(scan_code), 32'h1C);
        chk("v1c_latency", 32'(last_done_cyc), 32'(fall_cyc + FL + 3));
        chk("v1c_busy_after", 32'(busy), 32'd0);

        // Back-to-back F0 then 1C
        snap();
        send(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        chk("bb_f0_code", 32'(scan_code), 32'hF0);
        send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        chk("bb_1c_code", 32'(scan_code), 32'h1C);
        chk("bb_done", 32'(n_done - b_done), 32'd2);

        // Load F0 so an unchanged scan_code is distinguishable from 1C
        send(8'hF0, 1'b0, 1'b1, 11, 1'b0);
        chk("pre_f0_code", 32'(scan_code), 32'hF0);

        // Parity flipped on 0x1C
        snap();
        send(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        chk("par_perr", 32'(n_perr - b_perr), 32'd1);
        chk("par_done", 32'(n_done - b_done), 32'd0);
        chk("par_ferr", 32'(n_ferr - b_ferr), 32'd0);
        chk("par_code", 32'(scan_code), 32'hF0);

        // Stop bit low
        snap();
        send(8'h1C, 1'b0, 1'b0, 11, 1'b0);
        chk("stop_ferr", 32'(n_ferr - b_ferr), 32'd1);
        chk("stop_other", 32'(n_done - b_done + n_perr - b_perr), 32'd0);
        chk("stop_code", 32'(scan_code), 32'hF0);

        // Timeout after 5 bits
        snap();
        send(8'h1C, 1'b0, 1'b1, 5, 1'b0);
        chk("to_busy_mid", 32'(busy), 32'd1);
        repeat (TO + FL + 20) @(negedge clk);
        chk("to_ferr", 32'(n_ferr - b_ferr), 32'd1);
        chk("to_cycle", 32'(last_ferr_cyc), 32'(fall_cyc + FL + TO + 2));
        chk("to_busy_after", 32'(busy), 32'd0);
        snap();
        send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        chk("to_recover_done", 32'(n_done - b_done), 32'd1);
        chk("to_recover_code", 32'(scan_code), 32'h1C);

        // Glitch in idle
        snap();
        ps2c = 1'b0;
        repeat (3) @(negedge clk);
        ps2c = 1'b1;
        repeat (20) @(negedge clk);
        chk("gl_idle_busy", 32'(n_busy - b_busy), 32'd0);
        chk("gl_idle_ticks", 32'(n_done - b_done + n_perr - b_perr + n_ferr - b_ferr), 32'd0);

        // Glitch mid-frame: F0 must still arrive intact
        snap();
        send(8'hF0, 1'b0, 1'b1, 11, 1'b1);
        chk("gl_mid_done", 32'(n_done - b_done), 32'd1);
        chk("gl_mid_code", 32'(scan_code), 32'hF0);
        chk("gl_mid_errs", 32'(n_perr - b_perr + n_ferr - b_ferr), 32'd0);

        // rx_en low for a whole frame
        snap();
        rx_en = 1'b0;
        send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        chk("dis_busy", 32'(n_busy - b_busy), 32'd0);
        chk("dis_ticks", 32'(n_done - b_done + n_perr - b_perr + n_ferr - b_ferr), 32'd0);
        chk("dis_code", 32'(scan_code), 32'hF0);
        rx_en = 1'b1;

        // Reset mid-frame
        snap();
        send(8'h1C, 1'b0, 1'b1, 6, 1'b0);
        chk("rst_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_code", 32'(scan_code), 32'h00);
        chk("rst_ticks", 32'({scan_done_tick, parity_err_tick, frame_err_tick}), 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h1C, 1'b0, 1'b1, 11, 1'b0);
        chk("rst_recover_done", 32'(n_done - b_done), 32'd1);
        chk("rst_recover_errs", 32'(n_perr - b_perr + n_ferr - b_ferr), 32'd0);
        chk("rst_recover_code", 32'(scan_code), 32'h1C);

        chk("one_tick_max", 32'(n_multi), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 device-to-host serial receiver. Samples the raw ps2c/ps2d lines, debounces the clock, and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop). Delivers scan_code with a one-cycle scan_done_tick straight into the keyboard key-press controller, plus error ticks for bad frames.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised ps2c samples required to change the filtered clock level (range 2..16)
TIMEOUT_CYCLES, 200000, clk cycles without a filtered falling edge mid-frame before the frame is abandoned (2 ms at 100 MHz)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
ps2c  in  1  raw PS/2 clock pin, asynchronous
ps2d  in  1  raw PS/2 data pin, asynchronous
rx_en  in  1  1 = a new frame may start
scan_code  out  8  last correctly received data byte
scan_done_tick  out  1  one-cycle pulse: valid frame received, scan_code updated
parity_err_tick  out  1  one-cycle pulse: start/stop correct, parity wrong
frame_err_tick  out  1  one-cycle pulse: bad start/stop bit, or timeout
busy  out  1  1 while a frame is in progress (state != idle)

Behaviour:
- Reset (reset=0, async): state=idle, scan_code=8'h00, all ticks=0, busy=0, bit count=0, shift reg=0, timeout count=0, filtered clock=1, both sync chains=1.
- ps2c and ps2d each pass through a 2-FF synchroniser. ps2d is used unfiltered.
- Filter: shift register of the last FILTER_LEN synchronised ps2c samples. All ones -> filtered=1; all zeros -> filtered=0; otherwise hold.
- fall_edge = filtered_reg==1 && filtered_next==0. It is combinational and valid for exactly one cycle. The synchronised ps2d is sampled in that same cycle.
- FSM states: idle, dps, load.
  - idle: on fall_edge && rx_en, shift in ps2d (start bit), set bit count=9, clear timeout, go to dps. fall_edge with rx_en=0 is ignored.
  - dps: on fall_edge, shift ps2d into the MSB of an 11-bit right shift register and clear timeout. If count==0, go to load; else decrement count. With no fall_edge, timeout increments. At TIMEOUT_CYCLES-1: frame_err_tick=1, go to idle, shift reg discarded.
  - load: one cycle, then always go to idle.
- Frame checks in load, with frame = {stop, parity, d[7:0], start}:
  - start==0, stop==1 and ^{d,parity}==1: scan_code<=d, scan_done_tick=1.
  - start/stop correct, parity wrong: parity_err_tick=1, scan_code unchanged.
  - start!=0 or stop!=1: frame_err_tick=1, scan_code unchanged. Frame error has priority over parity error.
  - At most one tick is high in any cycle.
- Latency: edge 0 is the first clk edge at which sync stage 1 captures the ps2c falling edge for the stop bit. load is entered at edge FILTER_LEN+2, so scan_done_tick and the new scan_code are visible from edge FILTER_LEN+2 until edge FILTER_LEN+3. Exactly one pulse per frame.
- rx_en is sampled only in idle. Deasserting it mid-frame does not abort the frame.
- Back-to-back frames: a fall_edge arriving in the load cycle cannot happen, because the PS/2 bit period far exceeds FILTER_LEN+3 cycles. The next frame starts from idle normally.
- Glitches shorter than FILTER_LEN cycles on ps2c produce no edge.
- Reset asserted mid-frame returns to the reset state immediately. No tick is produced and the partial frame is lost.
- ps2d rising or falling while ps2c is high has no effect.

Decomposition:
- Package ps2_pkg: state encoding (idle=2'b00, dps=2'b01, load=2'b10), FRAME_BITS=11, DATA_BITS=8, BREAK_CODE=8'hF0.
- Sub-module ps2_clk_filter: holds both synchronisers and the debounce filter. Outputs the synchronised ps2d and fall_edge. ps2_rx holds the FSM, shift register, counters and checks.

Test Plan:
- Valid 0x1C frame (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) at a 50 us bit period -> one scan_done_tick at edge FILTER_LEN+2 after the stop edge, scan_code=8'h1C, no error ticks.
- Frames 0xF0 (parity 1) then 0x1C back-to-back -> two done ticks; scan_code reads 8'hF0, then 8'h1C.
- Frame 0x1C with parity bit flipped to 1 -> parity_err_tick=1 once, scan_code keeps its previous value, no done tick.
- Stop bit 0 -> frame_err_tick only. Separately, stop ps2c toggling after 5 bits -> frame_err_tick exactly TIMEOUT_CYCLES cycles after the last edge, busy=0; the following valid 0x1C frame is received correctly.
- 3-cycle low glitches on ps2c in idle and mid-frame -> no state change and no bit shift. rx_en=0 during a whole frame -> no ticks, busy stays 0.
- Pull reset low after 6 bits, then release and send 0x1C -> immediately busy=0 and scan_code=8'h00, no tick for the aborted frame, then scan_code=8'h1C with a single done tick.
